fill_rect_engine_p: RTL and testbench

Parametrised rectangle-fill engine that sits between the command processor and the framebuffer memory arbiter. It deserialises a byte-stream fill command, optionally clips it to the framebuffer, and emits one masked write per framebuffer word covered by the rectangle. It generalises the fixed 8-bit-per-pixel fill engine with configurable pixel depth, bus width, framebuffer geometry, a clip mode, and edge byte-enable masking.

---
 rtl/fill_rect_pkg.sv | 21 ++
 rtl/fill_rect_mask.sv | 20 ++
 rtl/fill_rect_engine_p.sv | 96 +++++++++
 tb/tb_fill_rect_engine_p.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fill_rect_pkg.sv
// fill_rect_pkg: shared states, mode bits and derived geometry for the rectangle-fill engine
package fill_rect_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL} state_t;
  localparam int MODE_CLIP = 0;
  function automatic int ppw(input int data_w, input int bpp);
    return data_w / bpp;
  endfunction
  function automatic int cb(input int bpp);
    return bpp / 8;
  endfunction
  function automatic int wpr(input int fb_w, input int data_w, input int bpp);
    return fb_w / ppw(data_w, bpp);
  endfunction
  function automatic int cmd_len(input int bpp);
    return 9 + cb(bpp);
  endfunction
  function automatic bit params_ok(input int data_w, input int bpp, input int fb_w);
    return (bpp == 8 || bpp == 16 || bpp == 32) && data_w % bpp == 0 &&
           (data_w & (data_w - 1)) == 0 && fb_w % ppw(data_w, bpp) == 0;
  endfunction
endpackage

// File: rtl/fill_rect_mask.sv
// fill_rect_mask: byte enables for the pixels of word wi that fall inside [x, x1)
module fill_rect_mask
  import fill_rect_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BPP    = 8
) (
  input  logic [16:0]         wi,
  input  logic [15:0]         x,
  input  logic [16:0]         x1,
  output logic [DATA_W/8-1:0] wben
);
  localparam int PPW = ppw(DATA_W, BPP);
  localparam int CB  = cb(BPP);
  for (genvar p = 0; p < PPW; p++) begin : g_px
    logic [31:0] pix;
    assign pix = 32'(wi) * 32'(PPW) + 32'(p);
    assign wben[p*CB +: CB] = {CB{pix >= 32'(x) && pix < 32'(x1)}};
  end
endmodule

// File: rtl/fill_rect_engine_p.sv
// fill_rect_engine_p: deserialises a fill command and emits one masked write per covered framebuffer word
module fill_rect_engine_p
  import fill_rect_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int BPP    = 8,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [7:0]          cmd_in_data,
  input  logic                cmd_in_rts,
  output logic                cmd_out_rtr,
  output logic [DATA_W-1:0]   arb_out_data,
  output logic [ADDR_W-1:0]   arb_out_addr,
  output logic [DATA_W/8-1:0] arb_out_wben,
  output logic                arb_out_op,
  output logic                arb_out_rts,
  input  logic                arb_in_rtr,
  output logic                busy
);
  localparam int PPW = ppw(DATA_W, BPP);
  localparam int WPR = wpr(FB_W, DATA_W, BPP);
  localparam int LEN = cmd_len(BPP);
  localparam int CW  = cb(BPP) * 8;
  localparam int F   = 64 + CW;
  if (!params_ok(DATA_W, BPP, FB_W)) begin : g_bad_params
    $error("fill_rect_engine_p: illegal DATA_W/BPP/FB_W combination");
  end
  state_t state, state_n;
  logic [3:0] cnt;
  logic [F-1:0] cmd;
  logic clip, take, hs, fill, empty, last_word, last_row;
  logic [15:0] x, y, w, h;
  logic [16:0] x1r, y1r, x1, y1, wf, wl, wi, cy;
  logic [ADDR_W-1:0] row_base;
  logic [DATA_W/8-1:0] mask;
  // The mode byte is captured on its own so the shift register holds only geometry and colour
  assign x = cmd[F-1 -: 16];
  assign y = cmd[F-17 -: 16];
  assign w = cmd[F-33 -: 16];
  assign h = cmd[F-49 -: 16];
  assign x1r = {1'b0, x} + {1'b0, w};
  assign y1r = {1'b0, y} + {1'b0, h};
  assign x1 = clip && x1r > 17'(FB_W) ? 17'(FB_W) : x1r;
  assign y1 = clip && y1r > 17'(FB_H) ? 17'(FB_H) : y1r;
  assign empty = w == '0 || h == '0 || (clip && (x >= 16'(FB_W) || y >= 16'(FB_H)));
  assign wf = {1'b0, x} / 17'(PPW);
  assign wl = (x1 - 17'd1) / 17'(PPW);
  assign last_word = wi == wl;
  assign last_row = cy == y1 - 17'd1;
  assign fill = state == S_FILL;
  assign take = cmd_in_rts && cmd_out_rtr;
  assign hs = arb_out_rts && arb_in_rtr;
  assign cmd_out_rtr = state == S_IDLE;
  assign busy = state != S_IDLE || cnt != '0;
  assign arb_out_rts = fill;
  assign arb_out_op = fill;
  assign arb_out_addr = fill ? row_base + ADDR_W'(wi) : '0;
  assign arb_out_data = fill ? {(DATA_W/CW){cmd[CW-1:0]}} : '0;
  assign arb_out_wben = fill ? mask : '0;
  fill_rect_mask #(.DATA_W(DATA_W), .BPP(BPP)) u_mask (
    .wi  (wi),
    .x   (x),
    .x1  (x1),
    .wben(mask)
  );
  always_comb begin
    state_n = state == S_IDLE  ? (take && cnt == 4'(LEN - 1) ? S_SETUP : S_IDLE) :
              state == S_SETUP ? (empty ? S_IDLE : S_FILL) :
              (hs && last_word && last_row ? S_IDLE : S_FILL);
  end
  always_ff @(posedge clk) begin
    if (rst_) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst_) cnt <= '0;
    else if (take) cnt <= cnt == 4'(LEN - 1) ? '0 : cnt + 4'd1;
    if (take && cnt == 4'd8) clip <= cmd_in_data[MODE_CLIP];
    else if (take) cmd <= {cmd[F-9:0], cmd_in_data};
    if (state == S_SETUP) begin
      wi <= wf;
      cy <= {1'b0, y};
      row_base <= ADDR_W'(32'(y) * 32'(WPR));
    end else if (hs && last_word) begin
      wi <= wf;
      cy <= cy + 17'd1;
      row_base <= row_base + ADDR_W'(WPR);
    end else if (hs) begin
      wi <= wi + 17'd1;
    end
  end
endmodule

// File: tb/tb_fill_rect_engine_p.sv
// tb_fill_rect_engine_p: randomized and directed checks of the fill engine against a pixel-level model
module tb_fill_rect_engine_p;
  logic clk = 0, rst_ = 0;
  logic [7:0] cmd_in_data = 0;
  logic cmd_in_rts = 0, cmd_out_rtr, arb_out_op, arb_out_rts, arb_in_rtr = 0, busy;
  logic [31:0] arb_out_data;
  logic [15:0] arb_out_addr;
  logic [3:0] arb_out_wben;
  logic [7:0] b_cmd_in_data = 0;
  logic b_cmd_in_rts = 0, b_cmd_out_rtr, b_arb_out_op, b_arb_out_rts, b_arb_in_rtr = 0, b_busy;
  logic [31:0] b_arb_out_data;
  logic [15:0] b_arb_out_addr;
  logic [3:0] b_arb_out_wben;
  typedef struct {int addr; int wben;} wr_t;
  wr_t exp_q[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  fill_rect_engine_p dut (
    .clk(clk), .rst_(rst_), .cmd_in_data(cmd_in_data), .cmd_in_rts(cmd_in_rts),
    .cmd_out_rtr(cmd_out_rtr), .arb_out_data(arb_out_data), .arb_out_addr(arb_out_addr),
    .arb_out_wben(arb_out_wben), .arb_out_op(arb_out_op), .arb_out_rts(arb_out_rts),
    .arb_in_rtr(arb_in_rtr), .busy(busy)
  );

  fill_rect_engine_p #(.BPP(16)) dut16 (
    .clk(clk), .rst_(rst_), .cmd_in_data(b_cmd_in_data), .cmd_in_rts(b_cmd_in_rts),
    .cmd_out_rtr(b_cmd_out_rtr), .arb_out_data(b_arb_out_data), .arb_out_addr(b_arb_out_addr),
    .arb_out_wben(b_arb_out_wben), .arb_out_op(b_arb_out_op), .arb_out_rts(b_arb_out_rts),
    .arb_in_rtr(b_arb_in_rtr), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Walk every pixel of the (clipped) rectangle; consecutive pixels of one word merge into one write
  function automatic void model(input int x, y, w, h, clip, ppw, cb, wpr, fbw, fbh);
    int x1, y1, cur, m;
    x1 = x + w;
    y1 = y + h;
    if (clip != 0 && x1 > fbw) x1 = fbw;
    if (clip != 0 && y1 > fbh) y1 = fbh;
    for (int r = y; r < y1; r++) begin
      cur = -1;
      m = 0;
      for (int p = x; p < x1; p++) begin
        if (p / ppw != cur && cur >= 0) begin
          exp_q.push_back('{(r * wpr + cur) & 32'hFFFF, m});
          m = 0;
        end
        cur = p / ppw;
        m |= ((1 << cb) - 1) << ((p % ppw) * cb);
      end
      if (cur >= 0) exp_q.push_back('{(r * wpr + cur) & 32'hFFFF, m});
    end
  endfunction

  task automatic send_byte(input logic [7:0] v, input bit stall);
    int n = 0;
    if (stall && $urandom_range(0, 2) == 0) begin
      cmd_in_rts = 0;
      @(negedge clk);
    end
    cmd_in_data = v;
    cmd_in_rts = 1;
    while (!cmd_out_rtr && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("rtr_timeout", cmd_out_rtr, 1);
    @(negedge clk);
    cmd_in_rts = 0;
  endtask

  task automatic send_cmd(input int x, y, w, h, input logic [7:0] mode, input logic [7:0] c, input bit stall);
    logic [7:0] b[10];
    b = '{x[15:8], x[7:0], y[15:8], y[7:0], w[15:8], w[7:0], h[15:8], h[7:0], mode, c};
    for (int i = 0; i < 10; i++) send_byte(b[i], stall);
  endtask

  task automatic run_cmd(input int x, y, w, h, input logic [7:0] mode, input logic [7:0] c, input bit stall);
    wr_t e;
    int n = 0;
    bit empty, held = 0;
    logic [15:0] pa;
    logic [31:0] pd;
    logic [3:0] pw;
    exp_q.delete();
    model(x, y, w, h, int'(mode[0]), 4, 1, 80, 320, 240);
    empty = exp_q.size() == 0;
    send_cmd(x, y, w, h, mode, c, stall);
    check("rtr_drop", cmd_out_rtr, 0);
    check("setup_rts", arb_out_rts, 0);
    @(negedge clk);
    check("first_rts", arb_out_rts, !empty);
    if (empty) begin
      check("empty_busy", busy, 0);
      check("empty_rtr", cmd_out_rtr, 1);
    end
    while (exp_q.size() > 0 && n < 2000) begin
      if (held) begin
        check("hold_rts", arb_out_rts, 1);
        check("hold_addr", arb_out_addr, pa);
        check("hold_data", arb_out_data, pd);
        check("hold_wben", arb_out_wben, pw);
      end
      if (!stall) check("b2b_rts", arb_out_rts, 1);
      arb_in_rtr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arb_out_rts && arb_in_rtr) begin
        e = exp_q.pop_front();
        check("addr", arb_out_addr, 64'(e.addr));
        check("wben", arb_out_wben, 64'(e.wben));
        check("data", arb_out_data, {4{c}});
        check("op", arb_out_op, 1);
        held = 0;
      end else begin
        held = arb_out_rts;
        pa = arb_out_addr;
        pd = arb_out_data;
        pw = arb_out_wben;
      end
      @(negedge clk);
      n++;
    end
    arb_in_rtr = 0;
    check("writes_left", exp_q.size(), 0);
    check("done_rtr", cmd_out_rtr, 1);
    check("done_rts", arb_out_rts, 0);
    check("done_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] b16[11];
    int n;
    rst_ = 1;
    repeat (3) @(negedge clk);
    check("rst_rtr", cmd_out_rtr, 1);
    check("rst_rts", arb_out_rts, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", arb_out_addr, 0);
    check("rst_data", arb_out_data, 0);
    check("rst_wben", arb_out_wben, 0);
    check("rst_op", arb_out_op, 0);
    rst_ = 0;
    @(negedge clk);
    run_cmd(32, 32, 4, 1, 8'h00, 8'h03, 0);
    run_cmd(1, 0, 6, 2, 8'h00, 8'hAB, 0);
    run_cmd(318, 0, 8, 1, 8'h01, 8'h5C, 0);
    run_cmd(318, 0, 8, 1, 8'hF0, 8'h5C, 0);
    run_cmd(10, 10, 0, 5, 8'h01, 8'h11, 0);
    run_cmd(10, 10, 7, 0, 8'h00, 8'h22, 0);
    run_cmd(400, 10, 5, 5, 8'h01, 8'h33, 0);
    run_cmd(4, 3, 16, 1, 8'h00, 8'h77, 1);
    run_cmd(0, 239, 4, 3, 8'h03, 8'h66, 1);
    send_cmd(0, 0, 16, 1, 8'h00, 8'h5A, 0);
    @(negedge clk);
    arb_in_rtr = 1;
    repeat (2) @(negedge clk);
    check("mid_addr", arb_out_addr, 2);
    arb_in_rtr = 0;
    rst_ = 1;
    @(negedge clk);
    rst_ = 0;
    check("abort_rts", arb_out_rts, 0);
    check("abort_rtr", cmd_out_rtr, 1);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h01, 0);
    rst_ = 1;
    @(negedge clk);
    rst_ = 0;
    check("partial_busy", busy, 0);
    run_cmd(5, 3, 3, 2, 8'h00, 8'hC3, 0);
    for (int i = 0; i < 40; i++)
      run_cmd($urandom_range(0, 340), $urandom_range(0, 250), $urandom_range(0, 24),
              $urandom_range(0, 3), 8'($urandom), 8'($urandom), 1'($urandom));
    b16 = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h12, 8'h34};
    exp_q.delete();
    model(1, 0, 1, 1, 0, 2, 2, 160, 320, 240);
    b_cmd_in_rts = 1;
    for (int i = 0; i < 11; i++) begin
      b_cmd_in_data = b16[i];
      check("b16_rtr", b_cmd_out_rtr, 1);
      @(negedge clk);
    end
    b_cmd_in_rts = 0;
    check("b16_len", b_cmd_out_rtr, 0);
    b_arb_in_rtr = 1;
    n = 0;
    while (!b_arb_out_rts && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b16_rts", b_arb_out_rts, 1);
    check("b16_addr", b_arb_out_addr, 64'(exp_q[0].addr));
    check("b16_wben", b_arb_out_wben, 64'(exp_q[0].wben));
    check("b16_data", b_arb_out_data, 32'h12341234);
    @(negedge clk);
    b_arb_in_rtr = 0;
    check("b16_done_rts", b_arb_out_rts, 0);
    check("b16_done_rtr", b_cmd_out_rtr, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
